// File: rtl/telas_transicao_if.sv
// Signal bundle between the VGA timing / per-screen generators and the
// transition compositor, plus read-only debug taps of the compositor state.
interface telas_transicao_if #(
    parameter int NUM_TELAS = 4,
    parameter int SEL_W     = 2,
    parameter int COR_W     = 8,
    parameter int FADE_LOG2 = 4
) ();
    // estado is a level request sampled every cycle; troca is a one-cycle
    // pulse qualified by a valid estado. There is no backpressure: ocupado is
    // status only, and requests are never lost, just retargeted.
    logic [9:0]                   h_counter;
    logic [9:0]                   v_counter;
    logic [SEL_W-1:0]             estado;
    logic                         troca;
    logic [NUM_TELAS*3*COR_W-1:0] rgb_in;
    logic [COR_W-1:0]             R;
    logic [COR_W-1:0]             G;
    logic [COR_W-1:0]             B;
    logic                         ocupado;
    logic [1:0]                   dbg_fsm;
    logic [FADE_LOG2:0]           dbg_nivel;
    logic [SEL_W-1:0]             dbg_tela_atual;

    modport master (
        output h_counter, v_counter, estado, troca, rgb_in,
        input  R, G, B, ocupado, dbg_fsm, dbg_nivel, dbg_tela_atual
    );

    modport slave (
        input  h_counter, v_counter, estado, troca, rgb_in,
        output R, G, B, ocupado, dbg_fsm, dbg_nivel, dbg_tela_atual
    );
endinterface

// File: rtl/telas_transicao.sv
// Screen compositor: picks one of NUM_TELAS sources by game state and fades
// out/in across a change, stepping brightness on frame boundaries.
module telas_transicao #(
    parameter int NUM_TELAS        = 4,
    parameter int SEL_W            = 2,
    parameter int COR_W            = 8,
    parameter int FADE_LOG2        = 4,
    parameter int FRAMES_POR_PASSO = 2,
    parameter int H_ATIVO          = 640,
    parameter int V_ATIVO          = 480
) (
    input logic              clk,
    input logic              reset,
    telas_transicao_if.slave bus
);
    localparam int NIVEL_W = FADE_LOG2 + 1;
    localparam int PROD_W  = COR_W + FADE_LOG2 + 1;
    localparam int PIX_W   = 3 * COR_W;
    localparam int CNT_W   = (FRAMES_POR_PASSO > 1) ? $clog2(FRAMES_POR_PASSO) : 1;
    localparam logic [NIVEL_W-1:0] NIVEL_MAX   = NIVEL_W'(1 << FADE_LOG2);
    localparam logic [NIVEL_W-1:0] NIVEL_QUASE = NIVEL_W'((1 << FADE_LOG2) - 1);
    localparam logic [NIVEL_W-1:0] NIVEL_UM    = NIVEL_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ULT     = CNT_W'(FRAMES_POR_PASSO - 1);
    localparam logic [SEL_W:0]     NUM_TELAS_L = (SEL_W + 1)'(NUM_TELAS);
    localparam logic [9:0]         H_LIM       = 10'(H_ATIVO);
    localparam logic [9:0]         V_LIM       = 10'(V_ATIVO);

    typedef enum logic [1:0] {
        ESTAVEL  = 2'd0,
        ESCURECE = 2'd1,
        CLAREIA  = 2'd2
    } fsm_t;

    fsm_t               fsm;
    logic [SEL_W-1:0]   tela_atual;
    logic [SEL_W-1:0]   tela_alvo;
    logic [NIVEL_W-1:0] nivel;
    logic [CNT_W-1:0]   cnt_frames;
    logic               origem_q;
    logic               ocupado_q;
    logic [COR_W-1:0]   r_q, g_q, b_q;

    logic             em_origem, frame_tick, step_tick, estado_ok, visivel;
    logic [SEL_W-1:0] alvo_eff;
    logic [PIX_W-1:0] pixel;

    assign em_origem  = (bus.h_counter == 10'd0) && (bus.v_counter == 10'd0);
    assign frame_tick = em_origem && !origem_q;
    assign step_tick  = frame_tick && (cnt_frames == CNT_ULT);
    assign estado_ok  = {1'b0, bus.estado} < NUM_TELAS_L;
    assign alvo_eff   = estado_ok ? bus.estado : tela_alvo;
    assign visivel    = (bus.h_counter < H_LIM) && (bus.v_counter < V_LIM);

    always_comb begin
        pixel = '0;
        for (int i = 0; i < NUM_TELAS; i++)
            if (tela_atual == SEL_W'(i)) pixel = bus.rgb_in[i*PIX_W +: PIX_W];
    end

    // Full-width product so nivel == 2^FADE_LOG2 reproduces c exactly.
    function automatic logic [COR_W-1:0] escala(input logic [COR_W-1:0] c,
                                                input logic [NIVEL_W-1:0] n);
        return COR_W'((PROD_W'(c) * PROD_W'(n)) >> FADE_LOG2);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else if (visivel) begin
            r_q <= escala(pixel[3*COR_W-1 -: COR_W], nivel);
            g_q <= escala(pixel[2*COR_W-1 -: COR_W], nivel);
            b_q <= escala(pixel[COR_W-1 -: COR_W], nivel);
        end else begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end
    end

    // Later assignments override the default cnt_frames advance, so any state
    // change drops a coincident frame tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm        <= ESTAVEL;
            tela_atual <= '0;
            tela_alvo  <= '0;
            nivel      <= NIVEL_MAX;
            cnt_frames <= '0;
            origem_q   <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            origem_q <= em_origem;
            if (frame_tick) cnt_frames <= step_tick ? '0 : cnt_frames + 1'b1;
            if (bus.troca && estado_ok) begin
                tela_atual <= bus.estado;
                tela_alvo  <= bus.estado;
                nivel      <= NIVEL_MAX;
                fsm        <= ESTAVEL;
                ocupado_q  <= 1'b0;
                if (fsm != ESTAVEL) cnt_frames <= '0;
            end else begin
                case (fsm)
                    ESTAVEL: begin
                        if (estado_ok && bus.estado != tela_atual) begin
                            tela_alvo  <= bus.estado;
                            fsm        <= ESCURECE;
                            ocupado_q  <= 1'b1;
                            cnt_frames <= '0;
                        end
                    end
                    ESCURECE: begin
                        tela_alvo <= alvo_eff;
                        if (alvo_eff == tela_atual) begin
                            fsm        <= CLAREIA;
                            cnt_frames <= '0;
                        end else if (step_tick) begin
                            if (nivel <= NIVEL_UM) begin
                                nivel      <= '0;
                                tela_atual <= alvo_eff;
                                fsm        <= CLAREIA;
                                cnt_frames <= '0;
                            end else begin
                                nivel <= nivel - 1'b1;
                            end
                        end
                    end
                    CLAREIA: begin
                        if (estado_ok && bus.estado != tela_atual) begin
                            tela_alvo  <= bus.estado;
                            fsm        <= ESCURECE;
                            cnt_frames <= '0;
                        end else if (nivel == NIVEL_MAX) begin
                            fsm        <= ESTAVEL;
                            ocupado_q  <= 1'b0;
                            cnt_frames <= '0;
                        end else if (step_tick) begin
                            nivel <= nivel + 1'b1;
                            if (nivel == NIVEL_QUASE) begin
                                fsm        <= ESTAVEL;
                                ocupado_q  <= 1'b0;
                                cnt_frames <= '0;
                            end
                        end
                    end
                    default: begin
                        fsm       <= ESTAVEL;
                        ocupado_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.R              = r_q;
    assign bus.G              = g_q;
    assign bus.B              = b_q;
    assign bus.ocupado        = ocupado_q;
    assign bus.dbg_fsm        = fsm;
    assign bus.dbg_nivel      = nivel;
    assign bus.dbg_tela_atual = tela_atual;
endmodule

// File: tb/tb_telas_transicao.sv
// Directed bench for telas_transicao: default 4-screen instance plus a
// 3-screen instance for out-of-range requests.
module tb_telas_transicao;
    localparam logic [23:0] S0 = 24'hFF8001;
    localparam logic [23:0] S1 = 24'h204060;
    localparam logic [23:0] S2 = 24'h123456;
    localparam logic [23:0] S3 = 24'hA5C3E7;
    localparam logic [1:0]  F_ESTAVEL  = 2'd0;
    localparam logic [1:0]  F_ESCURECE = 2'd1;
    localparam logic [1:0]  F_CLAREIA  = 2'd2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    telas_transicao_if #(.NUM_TELAS(4), .SEL_W(2), .COR_W(8), .FADE_LOG2(4)) bus4 ();
    telas_transicao_if #(.NUM_TELAS(3), .SEL_W(2), .COR_W(8), .FADE_LOG2(4)) bus3 ();

    telas_transicao #(.NUM_TELAS(4), .SEL_W(2), .COR_W(8), .FADE_LOG2(4),
                      .FRAMES_POR_PASSO(2), .H_ATIVO(640), .V_ATIVO(480))
        dut4 (.clk(clk), .reset(rst_n), .bus(bus4.slave));

    telas_transicao #(.NUM_TELAS(3), .SEL_W(2), .COR_W(8), .FADE_LOG2(4),
                      .FRAMES_POR_PASSO(2), .H_ATIVO(640), .V_ATIVO(480))
        dut3 (.clk(clk), .reset(rst_n), .bus(bus3.slave));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] rgb4();
        return {bus4.R, bus4.G, bus4.B};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_hv(input logic [9:0] h, input logic [9:0] v);
        bus4.h_counter = h;
        bus4.v_counter = v;
        bus3.h_counter = h;
        bus3.v_counter = v;
    endtask

    task automatic frame_tick(input int n);
        for (int i = 0; i < n; i++) begin
            set_hv(10'd0, 10'd0);
            step(1);
            set_hv(10'd10, 10'd10);
            step(1);
        end
    endtask

    initial begin
        logic [4:0] nmin;
        rst_n       = 1'b0;
        bus4.estado = 2'd0;
        bus4.troca  = 1'b0;
        bus4.rgb_in = {S3, S2, S1, S0};
        bus3.estado = 2'd0;
        bus3.troca  = 1'b0;
        bus3.rgb_in = {S2, S1, S0};
        set_hv(10'd10, 10'd10);

        // Reset with live sources
        step(3);
        check("rst_rgb", rgb4(), 24'h0);
        check("rst_ocupado", bus4.ocupado, 1'b0);
        check("rst_nivel", bus4.dbg_nivel, 5'd16);
        check("rst_fsm", bus4.dbg_fsm, F_ESTAVEL);
        rst_n = 1'b1;
        step(1);
        check("first_pixel", rgb4(), S0);

        // Full fade 0 -> 2
        bus4.estado = 2'd2;
        step(1);
        check("fade_ocupado_rise", bus4.ocupado, 1'b1);
        frame_tick(16);
        check("fade_mid_nivel", bus4.dbg_nivel, 5'd8);
        check("fade_mid_rgb", rgb4(), 24'h7F4000);
        frame_tick(16);
        check("fade_black_rgb", rgb4(), 24'h0);
        check("fade_black_tela", bus4.dbg_tela_atual, 2'd2);
        check("fade_black_fsm", bus4.dbg_fsm, F_CLAREIA);
        frame_tick(31);
        check("fade_almost_ocupado", bus4.ocupado, 1'b1);
        frame_tick(1);
        check("fade_end_ocupado", bus4.ocupado, 1'b0);
        check("fade_end_rgb", rgb4(), S2);

        // Forced cut at nivel 10
        bus4.estado = 2'd1;
        step(1);
        frame_tick(12);
        check("cut_pre_nivel", bus4.dbg_nivel, 5'd10);
        bus4.estado = 2'd3;
        bus4.troca  = 1'b1;
        step(1);
        bus4.troca  = 1'b0;
        check("cut_ocupado", bus4.ocupado, 1'b0);
        check("cut_tela", bus4.dbg_tela_atual, 2'd3);
        check("cut_nivel", bus4.dbg_nivel, 5'd16);
        step(1);
        check("cut_rgb", rgb4(), S3);

        // Reversal 0 -> 1 -> 0 at nivel 12
        bus4.estado = 2'd0;
        bus4.troca  = 1'b1;
        step(1);
        bus4.troca  = 1'b0;
        bus4.estado = 2'd1;
        step(1);
        check("rev_start_fsm", bus4.dbg_fsm, F_ESCURECE);
        frame_tick(8);
        check("rev_pre_nivel", bus4.dbg_nivel, 5'd12);
        bus4.estado = 2'd0;
        step(1);
        check("rev_fsm", bus4.dbg_fsm, F_CLAREIA);
        check("rev_tela", bus4.dbg_tela_atual, 2'd0);
        nmin = 5'd16;
        for (int i = 0; i < 8; i++) begin
            frame_tick(1);
            if (bus4.dbg_nivel < nmin) nmin = bus4.dbg_nivel;
        end
        check("rev_min_nivel", nmin, 5'd12);
        check("rev_end_nivel", bus4.dbg_nivel, 5'd16);
        check("rev_end_ocupado", bus4.ocupado, 1'b0);
        check("rev_end_rgb", rgb4(), S0);

        // Blanking limits
        set_hv(10'd640, 10'd10);
        step(1);
        check("blank_h", rgb4(), 24'h0);
        set_hv(10'd10, 10'd480);
        step(1);
        check("blank_v", rgb4(), 24'h0);
        set_hv(10'd639, 10'd479);
        step(1);
        check("visible_corner", rgb4(), S0);

        // Held origin counts as a single frame tick
        bus4.estado = 2'd1;
        step(1);
        set_hv(10'd0, 10'd0);
        step(5);
        set_hv(10'd10, 10'd10);
        step(1);
        check("hold_origin_nivel", bus4.dbg_nivel, 5'd16);
        frame_tick(1);
        check("hold_origin_step", bus4.dbg_nivel, 5'd15);

        // Out-of-range requests on the 3-screen instance
        bus3.estado = 2'd3;
        step(2);
        check("inv_ocupado", bus3.ocupado, 1'b0);
        check("inv_fsm", bus3.dbg_fsm, F_ESTAVEL);
        bus3.troca = 1'b1;
        step(1);
        bus3.troca = 1'b0;
        check("inv_troca_tela", bus3.dbg_tela_atual, 2'd0);
        bus3.estado = 2'd2;
        step(1);
        check("valid3_ocupado", bus3.ocupado, 1'b1);

        // Asynchronous reset in the middle of CLAREIA
        bus4.estado = 2'd0;
        step(1);
        check("mid_clareia_fsm", bus4.dbg_fsm, F_CLAREIA);
        rst_n = 1'b0;
        #1;
        check("async_rst_ocupado", bus4.ocupado, 1'b0);
        check("async_rst_rgb", rgb4(), 24'h0);
        check("async_rst_nivel", bus4.dbg_nivel, 5'd16);
        check("async_rst_fsm", bus4.dbg_fsm, F_ESTAVEL);
        check("async_rst_ocupado3", bus3.ocupado, 1'b0);
        rst_n = 1'b1;
        step(1);
        check("post_rst_rgb", rgb4(), S0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
